// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, stage
// indices and the forwarding priority helper.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_EXE     = 2'd0;
  localparam logic [1:0] FWD_MEM_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM_LD  = 2'd2;
  localparam logic [1:0] FWD_REG     = 2'd3;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  // The younger producer (EXE) shadows the older one (MEM).
  function automatic logic [1:0] fwd_pick(input logic exe_hit, input logic exe_ld,
                                          input logic mem_hit, input logic mem_ld);
    logic [1:0] sel;
    sel = FWD_REG;
    if (exe_hit) begin
      sel = exe_ld ? FWD_MEM_LD : FWD_EXE;
    end else if (mem_hit) begin
      sel = mem_ld ? FWD_MEM_LD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_scoreboard.sv
// Tracks in-flight multiply/divide results; a slot stops blocking in the cycle
// its countdown expires so the same cycle can reuse it.
module mdu_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MDU_LAT   = 4,
  parameter int MDU_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_addr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] wd_addr,
  output logic              rs_hit,
  output logic              rt_hit,
  output logic              wd_hit,
  output logic              full
);

  localparam int CW = $clog2(MDU_LAT + 1);

  logic [MDU_SLOTS-1:0] valid;
  logic [REG_AW-1:0]    slot_addr [MDU_SLOTS];
  logic [CW-1:0]        cnt       [MDU_SLOTS];
  logic [MDU_SLOTS-1:0] busy;
  logic [MDU_SLOTS-1:0] free_sel;
  logic                 found;

  always_comb begin
    busy   = '0;
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    wd_hit = 1'b0;
    for (int i = 0; i < MDU_SLOTS; i++) begin
      busy[i] = valid[i] && !(advance && cnt[i] == CW'(1));
      if (busy[i] && slot_addr[i] == rs_addr) rs_hit = 1'b1;
      if (busy[i] && slot_addr[i] == rt_addr) rt_hit = 1'b1;
      if (busy[i] && slot_addr[i] == wd_addr) wd_hit = 1'b1;
    end
  end

  assign full = &busy;

  always_comb begin
    free_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < MDU_SLOTS; i++) begin
      if (!busy[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < MDU_SLOTS; i++) begin
        slot_addr[i] <= '0;
        cnt[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < MDU_SLOTS; i++) begin
        if (issue && free_sel[i]) begin
          valid[i]     <= 1'b1;
          slot_addr[i] <= issue_addr;
          cnt[i]       <= CW'(MDU_LAT);
        end else if (advance && valid[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
          if (cnt[i] == CW'(1)) valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: forwarding, load-use and MDU
// stalls, per-stage rst/en. Optional single-step debug hold: HAZARD_DEBUG_STEP_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MDU_LAT     = 4,
  parameter int MDU_SLOTS   = 2,
  parameter int DELAY_SLOT  = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      id_rs_addr,
  input  logic [REG_AW-1:0]      id_rt_addr,
  input  logic [REG_AW-1:0]      id_wd_addr,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   id_is_store,
  input  logic                   id_wen,
  input  logic                   id_mdu,
  input  logic [REG_AW-1:0]      exe_wd_addr,
  input  logic [REG_AW-1:0]      mem_wd_addr,
  input  logic                   exe_wen,
  input  logic                   exe_mem_ren,
  input  logic                   mem_wen,
  input  logic                   mem_mem_ren,
  input  logic                   inst_stall,
  input  logic                   mem_stall,
  input  logic                   jump_en,
`ifdef HAZARD_DEBUG_STEP_EN
  input  logic                   debug_en,
  input  logic                   debug_step,
`endif
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   fwd_m,
  output logic [NUM_STG-1:0]     stg_rst,
  output logic [NUM_STG-1:0]     stg_en,
  output logic                   mdu_full,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic rs_exe, rs_mem, rt_exe, rt_mem;
  logic load_use, sb_stall, hold, advance, issue;
  logic sb_rs_hit, sb_rt_hit, sb_wd_hit;

  assign rs_exe = id_rs_used && id_rs_addr != '0 && exe_wen && exe_wd_addr == id_rs_addr;
  assign rs_mem = id_rs_used && id_rs_addr != '0 && mem_wen && mem_wd_addr == id_rs_addr;
  assign rt_exe = id_rt_used && id_rt_addr != '0 && exe_wen && exe_wd_addr == id_rt_addr;
  assign rt_mem = id_rt_used && id_rt_addr != '0 && mem_wen && mem_wd_addr == id_rt_addr;

  assign fwd_a = fwd_pick(rs_exe, exe_mem_ren, rs_mem, mem_mem_ren);
  assign fwd_b = fwd_pick(rt_exe, exe_mem_ren, rt_mem, mem_mem_ren);

  // Store data is not needed until MEM, so a load ahead of it forwards there.
  assign fwd_m    = rt_exe && exe_mem_ren && id_is_store;
  assign load_use = (rs_exe && exe_mem_ren) || (rt_exe && exe_mem_ren && !id_is_store);

  assign sb_stall = (id_rs_used && sb_rs_hit) || (id_rt_used && sb_rt_hit) ||
                    (id_wen && sb_wd_hit) || (id_mdu && mdu_full);

`ifdef HAZARD_DEBUG_STEP_EN
  logic debug_step_prev;

  always_ff @(posedge clk) begin
    if (rst) debug_step_prev <= 1'b0;
    else     debug_step_prev <= debug_step;
  end

  assign hold = debug_en && !(debug_step && !debug_step_prev);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    stg_rst = '0;
    stg_en  = '1;
    if (rst) begin
      stg_rst = '1;
    end else if (hold) begin
      stg_en = '0;
    end else if (inst_stall) begin
      stg_en[STG_IF]   = 1'b0;
      stg_en[STG_ID]   = 1'b0;
      stg_rst[STG_EXE] = 1'b1;
    end else if (mem_stall) begin
      stg_en[STG_IF]  = 1'b0;
      stg_en[STG_ID]  = 1'b0;
      stg_en[STG_EXE] = 1'b0;
      stg_rst[STG_WB] = 1'b1;
    end else if (load_use || sb_stall) begin
      stg_en[STG_IF]   = 1'b0;
      stg_en[STG_ID]   = 1'b0;
      stg_rst[STG_EXE] = 1'b1;
    end else if (jump_en && DELAY_SLOT == 0) begin
      stg_rst[STG_ID] = 1'b1;
    end
  end

  assign advance = !mem_stall && !hold;
  assign issue   = id_mdu && stg_en[STG_ID] && !stg_rst[STG_EXE] && id_wd_addr != '0;

  mdu_scoreboard #(
    .REG_AW    (REG_AW),
    .MDU_LAT   (MDU_LAT),
    .MDU_SLOTS (MDU_SLOTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .issue      (issue),
    .issue_addr (id_wd_addr),
    .rs_addr    (id_rs_addr),
    .rt_addr    (id_rt_addr),
    .wd_addr    (id_wd_addr),
    .rs_hit     (sb_rs_hit),
    .rt_hit     (sb_rt_hit),
    .wd_hit     (sb_wd_hit),
    .full       (mdu_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!stg_en[STG_IF] && !hold && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl with a queue-based reference
// model; a negedge monitor pops expected outputs and compares them.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int REG_AW    = 5;
  localparam int MDU_LAT   = 4;
  localparam int MDU_SLOTS = 2;
  localparam int SCW       = 4;
  localparam int SC_MAX    = 15;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fm;
    logic [4:0] sr;
    logic [4:0] se;
    logic [4:0] sr_ds;
    logic [4:0] se_ds;
    logic       full;
    logic [3:0] sc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct {
    logic [REG_AW-1:0] rd;
    int                rem;
  } flight_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, id_wd_addr, exe_wd_addr, mem_wd_addr;
  logic id_rs_used, id_rt_used, id_is_store, id_wen, id_mdu;
  logic exe_wen, exe_mem_ren, mem_wen, mem_mem_ren;
  logic inst_stall, mem_stall, jump_en;

  logic [1:0]     fwd_a, fwd_b, fwd_a_ds, fwd_b_ds;
  logic           fwd_m, fwd_m_ds, mdu_full, mdu_full_ds;
  logic [4:0]     stg_rst, stg_en, stg_rst_ds, stg_en_ds;
  logic [SCW-1:0] stall_cnt, stall_cnt_ds;

  hazard_ctrl #(
    .REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .MDU_SLOTS(MDU_SLOTS),
    .DELAY_SLOT(0), .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wd_addr(id_wd_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .id_wen(id_wen), .id_mdu(id_mdu),
    .exe_wd_addr(exe_wd_addr), .mem_wd_addr(mem_wd_addr),
    .exe_wen(exe_wen), .exe_mem_ren(exe_mem_ren), .mem_wen(mem_wen), .mem_mem_ren(mem_mem_ren),
    .inst_stall(inst_stall), .mem_stall(mem_stall), .jump_en(jump_en),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m), .stg_rst(stg_rst), .stg_en(stg_en),
    .mdu_full(mdu_full), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(
    .REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .MDU_SLOTS(MDU_SLOTS),
    .DELAY_SLOT(1), .STALL_CNT_W(SCW)
  ) dut_ds (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wd_addr(id_wd_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .id_wen(id_wen), .id_mdu(id_mdu),
    .exe_wd_addr(exe_wd_addr), .mem_wd_addr(mem_wd_addr),
    .exe_wen(exe_wen), .exe_mem_ren(exe_mem_ren), .mem_wen(mem_wen), .mem_mem_ren(mem_mem_ren),
    .inst_stall(inst_stall), .mem_stall(mem_stall), .jump_en(jump_en),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a(fwd_a_ds), .fwd_b(fwd_b_ds), .fwd_m(fwd_m_ds), .stg_rst(stg_rst_ds), .stg_en(stg_en_ds),
    .mdu_full(mdu_full_ds), .stall_cnt(stall_cnt_ds)
  );

  // reference model state
  logic [EW-1:0] exp_q[$];
  flight_t       fl[$];
  int            m_sc;
  bit            m_issue;
  exp_t          cur_e;
  exp_t          mon_e;
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    else n_pass++;
  endtask

  task automatic fwd_rule(input bit used, input logic [REG_AW-1:0] a, input bit store_rt,
                          output logic [1:0] sel, output bit lu, output bit fm);
    sel = 2'd3; lu = 1'b0; fm = 1'b0;
    if (used && a != 0) begin
      if (exe_wen && exe_wd_addr == a) begin
        sel = exe_mem_ren ? 2'd2 : 2'd0;
        if (exe_mem_ren) begin
          if (store_rt) fm = 1'b1;
          else lu = 1'b1;
        end
      end else if (mem_wen && mem_wd_addr == a) begin
        sel = mem_mem_ren ? 2'd2 : 2'd1;
      end
    end
  endtask

  task automatic model_eval(output exp_t e);
    int busy_n;
    bit rs_sb, rt_sb, wd_sb, lu_a, lu_b, fm_a, fm_b, sb;
    logic [1:0] fa, fb;
    busy_n = 0; rs_sb = 0; rt_sb = 0; wd_sb = 0;
    // An op whose last cycle elapses now no longer occupies anything.
    foreach (fl[k]) begin
      if (!(!mem_stall && fl[k].rem == 1)) begin
        busy_n++;
        if (fl[k].rd == id_rs_addr) rs_sb = 1;
        if (fl[k].rd == id_rt_addr) rt_sb = 1;
        if (fl[k].rd == id_wd_addr) wd_sb = 1;
      end
    end
    fwd_rule(id_rs_used, id_rs_addr, 1'b0, fa, lu_a, fm_a);
    fwd_rule(id_rt_used, id_rt_addr, id_is_store, fb, lu_b, fm_b);
    e.fa = fa; e.fb = fb; e.fm = fm_b;
    e.full = (busy_n >= MDU_SLOTS);
    sb = (id_rs_used && rs_sb) || (id_rt_used && rt_sb) || (id_wen && wd_sb) || (id_mdu && e.full);
    e.sr = 5'b00000; e.se = 5'b11111;
    if (rst) e.sr = 5'b11111;
    else if (inst_stall) begin e.se = 5'b11100; e.sr = 5'b00100; end
    else if (mem_stall) begin e.se = 5'b11000; e.sr = 5'b10000; end
    else if (lu_a || lu_b || sb) begin e.se = 5'b11100; e.sr = 5'b00100; end
    e.sr_ds = e.sr; e.se_ds = e.se;
    if (!rst && !inst_stall && !mem_stall && !(lu_a || lu_b || sb) && jump_en) e.sr = 5'b00010;
    e.sc = 4'(m_sc);
    m_issue = !rst && id_mdu && e.se[1] && !e.sr[2] && id_wd_addr != 0;
  endtask

  task automatic model_update();
    if (rst) begin
      fl.delete();
      m_sc = 0;
    end else begin
      if (!mem_stall) begin
        for (int k = fl.size() - 1; k >= 0; k--) begin
          fl[k].rem--;
          if (fl[k].rem == 0) fl.delete(k);
        end
      end
      if (m_issue) fl.push_back('{id_wd_addr, MDU_LAT});
      if (!cur_e.se[0] && m_sc < SC_MAX) m_sc++;
    end
  endtask

  // driver tasks
  task automatic clear_in();
    id_rs_addr = '0; id_rt_addr = '0; id_wd_addr = '0; exe_wd_addr = '0; mem_wd_addr = '0;
    id_rs_used = 0; id_rt_used = 0; id_is_store = 0; id_wen = 0; id_mdu = 0;
    exe_wen = 0; exe_mem_ren = 0; mem_wen = 0; mem_mem_ren = 0;
    inst_stall = 0; mem_stall = 0; jump_en = 0; rst = 0;
  endtask

  task automatic step();
    exp_t e;
    model_eval(e);
    cur_e = e;
    exp_q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mdu_op(input int rd);
    clear_in();
    id_mdu = 1; id_wen = 1; id_wd_addr = REG_AW'(rd);
  endtask

  task automatic reader(input int rs);
    clear_in();
    id_rs_used = 1; id_rs_addr = REG_AW'(rs); id_wen = 1; id_wd_addr = 5'd30;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("fwd_a", 32'(fwd_a), 32'(mon_e.fa));
      check("fwd_b", 32'(fwd_b), 32'(mon_e.fb));
      check("fwd_m", 32'(fwd_m), 32'(mon_e.fm));
      check("stg_rst", 32'(stg_rst), 32'(mon_e.sr));
      check("stg_en", 32'(stg_en), 32'(mon_e.se));
      check("stg_rst_ds", 32'(stg_rst_ds), 32'(mon_e.sr_ds));
      check("stg_en_ds", 32'(stg_en_ds), 32'(mon_e.se_ds));
      check("mdu_full", 32'(mdu_full), 32'(mon_e.full));
      check("stall_cnt", 32'(stall_cnt), 32'(mon_e.sc));
    end
  end

  initial begin
    clear_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    fl.delete();
    m_sc = 0;

    // reset state, idle
    clear_in(); steps(2);

    // ALU forwarding from EXE, then from MEM
    reader(3); exe_wen = 1; exe_wd_addr = 5'd3; step();
    reader(3); mem_wen = 1; mem_wd_addr = 5'd3; step();
    reader(3); exe_wen = 1; exe_wd_addr = 5'd3; mem_wen = 1; mem_wd_addr = 5'd3; mem_mem_ren = 1; step();
    reader(0); exe_wen = 1; exe_wd_addr = 5'd0; step();

    // load-use: one stall cycle, then load data from MEM
    reader(5); exe_wen = 1; exe_mem_ren = 1; exe_wd_addr = 5'd5; step();
    reader(5); mem_wen = 1; mem_mem_ren = 1; mem_wd_addr = 5'd5; step();

    // store after load: no stall, store data from MEM load
    clear_in(); id_is_store = 1; id_rt_used = 1; id_rt_addr = 5'd5; id_rs_used = 1; id_rs_addr = 5'd2;
    exe_wen = 1; exe_mem_ren = 1; exe_wd_addr = 5'd5; step();

    // MUL r8 then dependent read
    mdu_op(8); step();
    reader(8); steps(5);

    // same with a 2-cycle D-cache miss in the middle
    mdu_op(8); step();
    reader(8); step();
    mem_stall = 1; steps(2);
    mem_stall = 0; steps(5);

    // three back-to-back MDU ops against two slots
    mdu_op(9); step();
    mdu_op(10); step();
    mdu_op(11); steps(4);
    clear_in(); steps(6);

    // inst_stall beats jump; jump alone flushes ID only without a delay slot
    clear_in(); inst_stall = 1; jump_en = 1; step();
    clear_in(); jump_en = 1; step();
    clear_in(); steps(1);

    // stall counter saturation
    clear_in(); inst_stall = 1; steps(20);
    clear_in(); steps(1);

    // reset with both slots busy
    mdu_op(20); step();
    mdu_op(21); step();
    clear_in(); rst = 1; step();
    reader(20); id_mdu = 1; id_wd_addr = 5'd22; step();
    clear_in(); steps(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      clear_in();
      id_rs_addr  = REG_AW'($urandom_range(0, 7));
      id_rt_addr  = REG_AW'($urandom_range(0, 7));
      id_wd_addr  = REG_AW'($urandom_range(0, 7));
      exe_wd_addr = REG_AW'($urandom_range(0, 7));
      mem_wd_addr = REG_AW'($urandom_range(0, 7));
      id_rs_used  = ($urandom_range(0, 3) != 0);
      id_rt_used  = ($urandom_range(0, 1) != 0);
      id_is_store = ($urandom_range(0, 4) == 0);
      id_wen      = ($urandom_range(0, 1) != 0);
      id_mdu      = ($urandom_range(0, 5) == 0);
      exe_wen     = ($urandom_range(0, 1) != 0);
      exe_mem_ren = ($urandom_range(0, 2) == 0);
      mem_wen     = ($urandom_range(0, 1) != 0);
      mem_mem_ren = ($urandom_range(0, 2) == 0);
      inst_stall  = ($urandom_range(0, 9) == 0);
      mem_stall   = ($urandom_range(0, 9) == 0);
      jump_en     = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    clear_in(); steps(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
